// File: rtl/cam_i2c_pkg.sv
// Shared definitions for the MT9V034-style two-wire register responder.
package cam_i2c_pkg;

   localparam logic [6:0]  MT9V034_ADDR     = 7'h5C;
   localparam logic [15:0] MT9V034_CHIP_VER = 16'h1324;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_DEVADDR,
      ST_DEV_ACK,
      ST_REGADDR,
      ST_WR_HI,
      ST_WR_LO,
      ST_RD_HI,
      ST_RD_LO,
      ST_IGNORE
   } state_t;

   // States in which the initiator is shifting a byte into us.
   function automatic logic is_rx(input state_t s);
      return (s == ST_DEVADDR) || (s == ST_REGADDR) || (s == ST_WR_HI) || (s == ST_WR_LO);
   endfunction

   // States in which we are shifting a data byte out on SDA.
   function automatic logic is_tx(input state_t s);
      return (s == ST_RD_HI) || (s == ST_RD_LO);
   endfunction

endpackage

// File: rtl/i2c_line_filter.sv
// One bus line: 2-FF synchronizer, FILT_CYC-sample stability filter and
// single-clk rise/fall pulses on the filtered level.
module i2c_line_filter #(
   parameter int FILT_CYC = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic lvl,
   output logic rise,
   output logic fall
);

   logic [1:0] sync;
   logic [3:0] cnt;
   logic       lvl_d;

   // Synchronize, then accept a new level only after FILT_CYC equal samples.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync  <= 2'b11;
         cnt   <= 4'd0;
         lvl   <= 1'b1;
         lvl_d <= 1'b1;
      end else begin
         sync  <= {sync[0], raw};
         lvl_d <= lvl;
         if (sync[1] == lvl) begin
            cnt <= 4'd0;
         end else if (cnt == 4'(FILT_CYC - 1)) begin
            lvl <= sync[1];
            cnt <= 4'd0;
         end else begin
            cnt <= cnt + 4'd1;
         end
      end
   end

   assign rise = lvl & ~lvl_d;
   assign fall = ~lvl & lvl_d;

endmodule

// File: rtl/cam_i2c_responder.sv
// Two-wire register target: 7-bit device address, 8-bit register pointer,
// 16-bit data MSB byte first. SDA is driven open-drain through sda_oe only.
module cam_i2c_responder
   import cam_i2c_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = MT9V034_ADDR,
   parameter int         FILT_CYC = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        scl_in,
   input  logic        sda_in,
   output logic        sda_oe,
   output logic [7:0]  reg_addr,
   output logic [15:0] reg_wdata,
   output logic        reg_wr,
   output logic        reg_rd,
   input  logic [15:0] reg_rdata,
   output logic        busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_scl_filt (
      .clk(clk), .reset(reset), .raw(scl_in),
      .lvl(scl_lvl), .rise(scl_rise), .fall(scl_fall)
   );

   i2c_line_filter #(.FILT_CYC(FILT_CYC)) u_sda_filt (
      .clk(clk), .reset(reset), .raw(sda_in),
      .lvl(sda_lvl), .rise(sda_rise), .fall(sda_fall)
   );

   state_t      state, state_nxt;
   logic [3:0]  bit_cnt;     // 0..7 data bits, 8 = byte taken, 9 = ack bit sampled
   logic [7:0]  rx_sh;
   logic [7:0]  hi_byte;
   logic        rw;
   logic [15:0] tx_sh;
   logic        rd_d;        // reg_rdata is valid this clk
   logic        rd_pend;     // burst-read prefetch: reg_rd after the pointer bump

   logic       start_ev, stop_ev, bus_ev;
   logic [7:0] rx_byte;
   logic       active, take_bit, byte_in, dev_hit, rd_req;
   logic       ack_on, slot_rise, host_ack, slot_end, tx_shift, tx_release, cnt_inc;

   assign start_ev = sda_fall & scl_lvl;
   assign stop_ev  = sda_rise & scl_lvl;
   assign bus_ev   = start_ev | stop_ev;
   assign rx_byte  = {rx_sh[6:0], sda_lvl};

   // Decode bit-level events for the current state; bus conditions mask SCL edges.
   always_comb begin
      active     = (state != ST_IDLE) && (state != ST_IGNORE);
      cnt_inc    = scl_rise & ~bus_ev & active & (bit_cnt < 4'd9);
      take_bit   = scl_rise & ~bus_ev & is_rx(state) & (bit_cnt < 4'd8);
      byte_in    = take_bit & (bit_cnt == 4'd7);
      dev_hit    = byte_in & (state == ST_DEVADDR) & (rx_byte[7:1] == DEV_ADDR);
      rd_req     = dev_hit & rx_byte[0];
      ack_on     = scl_fall & ~bus_ev & (bit_cnt == 4'd8) &
                   ((state == ST_DEV_ACK) || (state == ST_REGADDR) ||
                    (state == ST_WR_HI)   || (state == ST_WR_LO));
      slot_rise  = scl_rise & ~bus_ev & active & (bit_cnt == 4'd8);
      host_ack   = slot_rise & is_tx(state) & ~sda_lvl;
      slot_end   = scl_fall & ~bus_ev & active & (bit_cnt == 4'd9);
      tx_shift   = scl_fall & ~bus_ev & is_tx(state) & (bit_cnt >= 4'd1) & (bit_cnt <= 4'd7);
      tx_release = scl_fall & ~bus_ev & is_tx(state) & (bit_cnt == 4'd8);
   end

   // Next state: stop and start override everything, else advance per byte slot.
   always_comb begin
      state_nxt = state;
      if (stop_ev) begin
         state_nxt = ST_IDLE;
      end else if (start_ev) begin
         state_nxt = ST_DEVADDR;
      end else begin
         case (state)
            ST_DEVADDR: if (byte_in)  state_nxt = dev_hit ? ST_DEV_ACK : ST_IGNORE;
            ST_DEV_ACK: if (slot_end) state_nxt = rw ? ST_RD_HI : ST_REGADDR;
            ST_REGADDR: if (slot_end) state_nxt = ST_WR_HI;
            ST_WR_HI:   if (slot_end) state_nxt = ST_WR_LO;
            ST_WR_LO:   if (slot_end) state_nxt = ST_WR_HI;
            ST_RD_HI: begin
               if (slot_rise && sda_lvl) state_nxt = ST_IGNORE;
               else if (slot_end)        state_nxt = ST_RD_LO;
            end
            ST_RD_LO: begin
               if (slot_rise && sda_lvl) state_nxt = ST_IGNORE;
               else if (slot_end)        state_nxt = ST_RD_HI;
            end
            default: state_nxt = state;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Datapath: shifters, register-file strobes, pointer and the SDA pull-down.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bit_cnt   <= 4'd0;
         rx_sh     <= 8'd0;
         hi_byte   <= 8'd0;
         rw        <= 1'b0;
         tx_sh     <= 16'd0;
         rd_d      <= 1'b0;
         rd_pend   <= 1'b0;
         sda_oe    <= 1'b0;
         reg_addr  <= 8'd0;
         reg_wdata <= 16'd0;
         reg_wr    <= 1'b0;
         reg_rd    <= 1'b0;
         busy      <= 1'b0;
      end else begin
         reg_wr  <= 1'b0;
         reg_rd  <= rd_req | rd_pend;
         rd_pend <= host_ack & (state == ST_RD_LO);
         rd_d    <= reg_rd;

         if (bus_ev)        bit_cnt <= 4'd0;
         else if (slot_end) bit_cnt <= 4'd0;
         else if (cnt_inc)  bit_cnt <= bit_cnt + 4'd1;

         if (take_bit) rx_sh <= rx_byte;
         if (dev_hit)  rw    <= rx_byte[0];
         if (byte_in && state == ST_WR_HI) hi_byte <= rx_byte;
         if (byte_in && state == ST_WR_LO) begin
            reg_wdata <= {hi_byte, rx_byte};
            reg_wr    <= 1'b1;
         end

         // Pointer bumps after a completed write and ahead of each burst-read prefetch.
         if (byte_in && state == ST_REGADDR)
            reg_addr <= rx_byte;
         else if (reg_wr || (host_ack && state == ST_RD_LO))
            reg_addr <= reg_addr + 8'd1;

         if (rd_d)
            tx_sh <= reg_rdata;
         else if (tx_shift || (slot_end && state == ST_RD_HI))
            tx_sh <= {tx_sh[14:0], 1'b0};

         // SDA only moves on the clk after a filtered SCL fall, or on a bus condition.
         if (bus_ev)
            sda_oe <= 1'b0;
         else if (ack_on)
            sda_oe <= 1'b1;
         else if (tx_shift)
            sda_oe <= ~tx_sh[14];
         else if (tx_release)
            sda_oe <= 1'b0;
         else if (slot_end) begin
            if (state == ST_RD_HI)         sda_oe <= ~tx_sh[14];
            else if (state_nxt == ST_RD_HI) sda_oe <= ~tx_sh[15];
            else                            sda_oe <= 1'b0;
         end

         if (start_ev)     busy <= 1'b1;
         else if (stop_ev) busy <= 1'b0;
      end
   end

endmodule

// File: tb/tb_cam_i2c_responder.sv
// Bench for cam_i2c_responder: bit-banged initiator, a register file on the
// reg_* side, and a word-level reference model of the expected transactions.
module tb_cam_i2c_responder;
   import cam_i2c_pkg::*;

   localparam int Q = 10;  // quarter SCL period in clks

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        scl_m = 1'b1, sda_m = 1'b1;
   logic        scl_in, sda_in, sda_oe, reg_wr, reg_rd, busy;
   logic [7:0]  reg_addr;
   logic [15:0] reg_wdata, reg_rdata;

   int vectors = 0, miscompares = 0;

   typedef struct packed { logic [7:0] a; logic [15:0] d; } wr_t;
   logic [15:0] rf      [256];
   logic [15:0] ref_mem [256];
   wr_t         wr_log  [$];
   logic [7:0]  rd_log  [$];
   int          oe_cycles = 0;

   assign scl_in = scl_m;
   assign sda_in = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   cam_i2c_responder #(.DEV_ADDR(7'h5C), .FILT_CYC(3)) dut (
      .clk(clk), .reset(reset), .scl_in(scl_in), .sda_in(sda_in), .sda_oe(sda_oe),
      .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_wr(reg_wr), .reg_rd(reg_rd),
      .reg_rdata(reg_rdata), .busy(busy)
   );

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return (a == 8'h00) ? MT9V034_CHIP_VER : {a ^ 8'hA5, ~a};
   endfunction

   // Register file: read data valid one clk after reg_rd.
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 256; i++) rf[i] <= init_val(8'(i));
      end else begin
         if (reg_rd) reg_rdata <= rf[reg_addr];
         if (reg_wr) rf[reg_addr] <= reg_wdata;
      end
   end

   always @(negedge clk) begin
      if (reg_wr) wr_log.push_back({reg_addr, reg_wdata});
      if (reg_rd) rd_log.push_back(reg_addr);
      if (sda_oe) oe_cycles++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bit_xfer(input logic b, input int glitch, output logic seen);
      tick(Q);
      sda_m = b;
      if (glitch > 0) begin
         tick(2); scl_m = 1'b1; tick(glitch); scl_m = 1'b0; tick(Q - 2 - glitch);
      end else begin
         tick(Q);
      end
      scl_m = 1'b1; tick(Q);
      seen = sda_in; tick(Q);
      scl_m = 1'b0;
   endtask

   task automatic i2c_start();
      if (scl_m == 1'b0) begin
         tick(Q); sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q);
      end
      sda_m = 1'b0; tick(Q); scl_m = 1'b0;
   endtask

   task automatic i2c_stop();
      tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
   endtask

   task automatic wr_byte(input logic [7:0] b, input int glitch, output logic ack);
      logic s;
      for (int i = 7; i >= 0; i--) bit_xfer(b[i], glitch, s);
      bit_xfer(1'b1, 0, s);
      ack = ~s;
   endtask

   task automatic rd_byte(input logic ack, output logic [7:0] d);
      logic s;
      for (int i = 7; i >= 0; i--) begin
         bit_xfer(1'b1, 0, s);
         d[i] = s;
      end
      bit_xfer(~ack, 0, s);
   endtask

   task automatic test_reset();
      tick(4);
      vectors++; if (sda_oe !== 1'b0)       begin miscompares++; $display("FAIL reset_sda_oe: got %b want 0", sda_oe); end
      vectors++; if (reg_addr !== 8'h00)    begin miscompares++; $display("FAIL reset_reg_addr: got %h want 00", reg_addr); end
      vectors++; if (reg_wdata !== 16'h0)   begin miscompares++; $display("FAIL reset_reg_wdata: got %h want 0000", reg_wdata); end
      vectors++; if (reg_wr !== 1'b0)       begin miscompares++; $display("FAIL reset_reg_wr: got %b want 0", reg_wr); end
      vectors++; if (reg_rd !== 1'b0)       begin miscompares++; $display("FAIL reset_reg_rd: got %b want 0", reg_rd); end
      vectors++; if (busy !== 1'b0)         begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
      reset = 1'b0;
      tick(4);
      vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d want IDLE", dut.state); end
   endtask

   // Single-word write; glitch > 0 adds short SCL pulses inside every data bit.
   task automatic test_write(input logic [7:0] a, input logic [15:0] d, input int glitch);
      logic [3:0] ak;
      int w0;
      w0 = wr_log.size();
      i2c_start();
      wr_byte(8'hB8, 0, ak[0]);
      wr_byte(a, glitch, ak[1]);
      wr_byte(d[15:8], glitch, ak[2]);
      wr_byte(d[7:0], glitch, ak[3]);
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL write_busy_mid: got %b want 1", busy); end
      i2c_stop();
      ref_mem[a] = d;
      vectors++; if (ak !== 4'hF) begin miscompares++; $display("FAIL write_acks: got %b want 1111", ak); end
      vectors++;
      if (wr_log.size() - w0 != 1) begin
         miscompares++; $display("FAIL write_count: got %0d want 1", wr_log.size() - w0);
      end else if (wr_log[w0] !== {a, d}) begin
         miscompares++; $display("FAIL write_data: got %h want %h", wr_log[w0], {a, d});
      end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL write_busy_end: got %b want 0", busy); end
      vectors++; if (reg_addr !== 8'(a + 1)) begin miscompares++; $display("FAIL write_ptr: got %h want %h", reg_addr, 8'(a + 1)); end
   endtask

   // Set pointer, repeated start, read n words (last low byte NACKed).
   task automatic test_read(input logic [7:0] a, input int n);
      logic [2:0] ak;
      logic [7:0] hi, lo;
      int r0;
      r0 = rd_log.size();
      i2c_start();
      wr_byte(8'hB8, 0, ak[0]);
      wr_byte(a, 0, ak[1]);
      i2c_start();
      wr_byte(8'hB9, 0, ak[2]);
      vectors++; if (ak !== 3'b111) begin miscompares++; $display("FAIL read_acks: got %b want 111", ak); end
      for (int w = 0; w < n; w++) begin
         rd_byte(1'b1, hi);
         rd_byte(w != n - 1, lo);
         vectors++;
         if ({hi, lo} !== ref_mem[8'(a + w)]) begin
            miscompares++; $display("FAIL read_data[%0d]: got %h want %h", w, {hi, lo}, ref_mem[8'(a + w)]);
         end
      end
      tick(8);
      vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL read_release: got %b want 0", sda_oe); end
      i2c_stop();
      vectors++;
      if (rd_log.size() - r0 != n) begin
         miscompares++; $display("FAIL read_count: got %0d want %0d", rd_log.size() - r0, n);
      end else begin
         for (int w = 0; w < n; w++) begin
            if (rd_log[r0 + w] !== 8'(a + w)) begin
               miscompares++; $display("FAIL read_addr[%0d]: got %h want %h", w, rd_log[r0 + w], 8'(a + w));
            end
         end
      end
      vectors++; if (reg_addr !== 8'(a + n - 1)) begin miscompares++; $display("FAIL read_ptr: got %h want %h", reg_addr, 8'(a + n - 1)); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL read_busy_end: got %b want 0", busy); end
   endtask

   // Foreign device address: bus must stay untouched, then a normal write works.
   task automatic test_ignore(input logic [7:0] dev);
      logic [3:0] ak;
      int w0, r0, oe0;
      w0 = wr_log.size(); r0 = rd_log.size(); oe0 = oe_cycles;
      i2c_start();
      wr_byte(dev, 0, ak[0]);
      for (int k = 1; k < 4; k++) wr_byte(8'($urandom_range(0, 255)), 0, ak[k]);
      i2c_stop();
      vectors++; if (oe_cycles !== oe0) begin miscompares++; $display("FAIL ignore_sda_oe: got %0d driven clks want 0", oe_cycles - oe0); end
      vectors++; if (ak !== 4'h0) begin miscompares++; $display("FAIL ignore_acks: got %b want 0000", ak); end
      vectors++;
      if (wr_log.size() != w0 || rd_log.size() != r0) begin
         miscompares++; $display("FAIL ignore_strobes: got wr %0d rd %0d want 0 0", wr_log.size() - w0, rd_log.size() - r0);
      end
      test_write(8'($urandom_range(0, 255)), 16'($urandom), 0);
   endtask

   task automatic test_burst_wrap();
      logic [5:0] ak;
      int w0;
      w0 = wr_log.size();
      i2c_start();
      wr_byte(8'hB8, 0, ak[0]);
      wr_byte(8'hFF, 0, ak[1]);
      wr_byte(8'h00, 0, ak[2]);
      wr_byte(8'h01, 0, ak[3]);
      wr_byte(8'h00, 0, ak[4]);
      wr_byte(8'h02, 0, ak[5]);
      i2c_stop();
      ref_mem[8'hFF] = 16'h0001;
      ref_mem[8'h00] = 16'h0002;
      vectors++; if (ak !== 6'h3F) begin miscompares++; $display("FAIL burst_acks: got %b want 111111", ak); end
      vectors++;
      if (wr_log.size() - w0 != 2) begin
         miscompares++; $display("FAIL burst_count: got %0d want 2", wr_log.size() - w0);
      end else if (wr_log[w0] !== {8'hFF, 16'h0001} || wr_log[w0 + 1] !== {8'h00, 16'h0002}) begin
         miscompares++; $display("FAIL burst_data: got %h %h want ff0001 000002", wr_log[w0], wr_log[w0 + 1]);
      end
      vectors++; if (reg_addr !== 8'h01) begin miscompares++; $display("FAIL burst_ptr: got %h want 01", reg_addr); end
   endtask

   task automatic test_partial();
      logic [7:0] a;
      logic [2:0] ak;
      logic s;
      int w0;
      a = 8'($urandom_range(0, 255));
      w0 = wr_log.size();
      i2c_start();
      wr_byte(8'hB8, 0, ak[0]);
      wr_byte(a, 0, ak[1]);
      wr_byte(8'($urandom_range(0, 255)), 0, ak[2]);
      for (int i = 0; i < 4; i++) bit_xfer(1'($urandom_range(0, 1)), 0, s);
      i2c_stop();
      vectors++; if (wr_log.size() != w0) begin miscompares++; $display("FAIL partial_no_write: got %0d writes want 0", wr_log.size() - w0); end
      vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL partial_state: got %0d want IDLE", dut.state); end
      vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL partial_sda_oe: got %b want 0", sda_oe); end
      vectors++; if (reg_addr !== a) begin miscompares++; $display("FAIL partial_ptr: got %h want %h", reg_addr, a); end
   endtask

   // Reset while a zero word is being shifted out (SDA held low).
   task automatic test_reset_mid();
      logic [7:0] a;
      logic [2:0] ak;
      logic s;
      int w0, r0;
      a = 8'($urandom_range(1, 254));
      test_write(a, 16'h0000, 0);
      i2c_start();
      wr_byte(8'hB8, 0, ak[0]);
      wr_byte(a, 0, ak[1]);
      i2c_start();
      wr_byte(8'hB9, 0, ak[2]);
      for (int i = 0; i < 3; i++) bit_xfer(1'b1, 0, s);
      tick(Q);
      vectors++; if (sda_oe !== 1'b1) begin miscompares++; $display("FAIL rstmid_driving: got %b want 1", sda_oe); end
      w0 = wr_log.size(); r0 = rd_log.size();
      reset = 1'b1;
      #1;
      vectors++; if (sda_oe !== 1'b0) begin miscompares++; $display("FAIL rstmid_sda_oe: got %b want 0", sda_oe); end
      vectors++;
      if (reg_addr !== 8'h00 || reg_wdata !== 16'h0 || reg_wr !== 1'b0 || reg_rd !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL rstmid_outputs: got %h %h %b %b %b want 00 0000 0 0 0", reg_addr, reg_wdata, reg_wr, reg_rd, busy);
      end
      vectors++; if (dut.state !== ST_IDLE) begin miscompares++; $display("FAIL rstmid_state: got %0d want IDLE", dut.state); end
      scl_m = 1'b1; sda_m = 1'b1;
      tick(5);
      reset = 1'b0;
      tick(5);
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      vectors++;
      if (wr_log.size() != w0 || rd_log.size() != r0) begin
         miscompares++; $display("FAIL rstmid_strobes: got wr %0d rd %0d want 0 0", wr_log.size() - w0, rd_log.size() - r0);
      end
      test_read(8'h00, 1);
   endtask

   initial begin
      logic [6:0] foreign;
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
      test_reset();
      test_write(8'h07, 16'h0388, 0);
      test_read(8'h00, 1);
      for (int k = 0; k < 3; k++) test_write(8'($urandom_range(0, 255)), 16'($urandom), 0);
      test_read(8'($urandom_range(0, 255)), 3);
      test_ignore(8'h90);
      do foreign = 7'($urandom_range(0, 127)); while (foreign == 7'h5C);
      test_ignore({foreign, 1'($urandom_range(0, 1))});
      test_burst_wrap();
      test_read(8'hFF, 2);
      test_partial();
      test_write(8'($urandom_range(0, 255)), 16'($urandom), 1);
      test_write(8'($urandom_range(0, 255)), 16'($urandom), 2);
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/cam_i2c_responder.md
Name: cam_i2c_responder

Overview:
- I2C target (responder) emulating the MT9V034 two-wire serial register interface: 7-bit device address, 8-bit register address, 16-bit data sent MSB byte first.
- It is the counterpart to the camera-side I2C initiator. It answers that initiator in loopback and simulation benches, and fronts an on-FPGA register file.
- Oversamples SCL/SDA on the system clock. Drives SDA open-drain through an output-enable only.

Parameters:
- DEV_ADDR, 7'h5C, 7-bit target address; bus bytes are 0xB8 for write and 0xB9 for read.
- FILT_CYC, 3, number of consecutive equal samples required before a filtered SCL/SDA level changes. Range 1..15.

Ports:
- clk  in  1  system clock; at least 20x SCL frequency (24 MHz nominal).
- reset  in  1  asynchronous, active-high; clears all state.
- scl_in  in  1  raw SCL pad level.
- sda_in  in  1  raw SDA pad level.
- sda_oe  out  1  1 = pull SDA low; 0 = release. The pad ties the output data to 0.
- reg_addr  out  8  current register pointer.
- reg_wdata  out  16  write data, valid while reg_wr=1.
- reg_wr  out  1  one-clk write strobe.
- reg_rd  out  1  one-clk read request.
- reg_rdata  in  16  read data, valid exactly 1 clk after reg_rd.
- busy  out  1  1 from START until STOP.

Behaviour:
- Input conditioning: SCL and SDA each pass a 2-FF synchronizer, then a FILT_CYC-sample stable filter.
- Edge events: scl_rise, scl_fall, start (SDA falls while SCL=1), stop (SDA rises while SCL=1). Each is a single-clk pulse derived from the filtered levels.
- Reset values: sda_oe=0, reg_addr=0, reg_wdata=0, reg_wr=0, reg_rd=0, busy=0, state=IDLE, filtered levels=1.
- Bit timing: data bits are sampled on scl_rise. sda_oe changes only on the clk after scl_fall.
- ACK timing: sda_oe=1 from the scl_fall that ends bit 8 until the scl_fall that ends bit 9.
- States and transitions:
  - IDLE: wait for start.
  - DEVADDR: shift in 8 bits.
    - If addr[7:1]==DEV_ADDR, go to DEV_ACK.
    - Otherwise go to IGNORE. No ACK is driven; stay silent until start or stop.
  - DEV_ACK:
    - R/W=0: go to REGADDR.
    - R/W=1: pulse reg_rd on the clk after bit-8 sample; latch reg_rdata into the 16-bit tx shifter the next clk; go to RD_HI.
  - REGADDR: 8 bits, then ACK. Load reg_addr, then go to WR_HI.
  - WR_HI: 8 bits, then ACK; hold the high byte, go to WR_LO.
  - WR_LO: 8 bits, then ACK.
    - On the clk after the 8th bit sample: reg_wdata={hi,lo}, reg_wr=1 for one clk.
    - reg_addr increments (8-bit wrap, 0xFF->0x00) on the clk after reg_wr.
    - Return to WR_HI.
  - RD_HI / RD_LO:
    - Drive sda_oe=~bit (MSB first) for 8 bits.
    - Release SDA for the initiator ACK slot and sample it on scl_rise.
    - Initiator ACK (0): RD_HI goes to RD_LO. RD_LO increments reg_addr, issues a new reg_rd, reloads the shifter, and goes to RD_HI.
    - Initiator NACK (1): go to IGNORE with reg_addr unchanged after any increment already done.
- Global overrides:
  - start in any state (repeated start) aborts the current byte, clears the bit counter and goes to DEVADDR. reg_addr is retained, so write-pointer-then-restart-read works.
  - stop in any state goes to IDLE with sda_oe=0.
  - A partial word is never written. reg_wr fires only on a complete low byte.
- busy is set on start and cleared on stop or reset.
- Simultaneous start and scl edge: start/stop takes priority.
- Reset mid-transfer: immediate release of SDA, state=IDLE, and no strobe is issued.

Decomposition:
- Shared package cam_i2c_pkg: state enum; constants MT9V034_ADDR=7'h5C and MT9V034_CHIP_VER=16'h1324.
- Sub-module i2c_line_filter: one sync + stable filter + rise/fall pulse, instantiated twice (SCL, SDA). Start/stop decode stays in the top.

Test Plan:
- Write 0xB8, 0x07, 0x03, 0x88, stop:
  - ACK on all 4 bytes.
  - Exactly one reg_wr with reg_addr=0x07, reg_wdata=0x0388.
  - busy returns 0 after stop.
- Write 0xB8, 0x00, repeated start, 0xB9, read 2 bytes with ACK then NACK; model returns 0x1324:
  - one reg_rd at addr 0x00.
  - SDA bits 0x13 then 0x24.
  - SDA released after NACK.
- Address 0x90:
  - sda_oe stays 0 for the whole transfer.
  - no reg_rd or reg_wr.
  - next 0xB8 transfer is ACKed normally.
- Burst write 0xB8, 0xFF, 0x00, 0x01, 0x00, 0x02:
  - two reg_wr, at addr 0xFF (data 0x0001) then 0x00 (data 0x0002), showing pointer wrap.
- Stop after 4 bits of the low data byte:
  - no reg_wr.
  - state IDLE, sda_oe=0.
- Assert reset during the RD_HI byte:
  - sda_oe=0 within one clk.
  - all outputs at reset values.
- Separately, inject 1-clk SCL glitches shorter than FILT_CYC: no bit is sampled.
